// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path constants and types
package cpu_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  // An all-zero word is treated by the pipeline as a bubble
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAIT_DROP
  } fetch_state_t;

endpackage

// File: rtl/ipb_fifo.sv
// rtl/ipb_fifo.sv - synchronous FIFO holding {addr, instr} prefetch entries
module ipb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointer and occupancy tracking; clear wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; a cleared cycle never writes
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_buffer.sv
// rtl/inst_prefetch_buffer.sv - sequential instruction prefetcher with redirect flush
module inst_prefetch_buffer
  import cpu_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic [ADDR_W-1:0]      cpu_addr,
  output logic                   fetch_valid,
  output logic [INSTR_W-1:0]     fetch_instr,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_W-1:0]     mem_rdata,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t               state_q, state_d;
  logic [ADDR_W-1:0]          issue_addr_q, issue_addr_d;
  logic [ADDR_W-1:0]          mem_addr_d;
  logic                       mem_req_d;
  logic [ADDR_W+INSTR_W-1:0]  head_data;
  logic [ADDR_W-1:0]          head_addr;
  logic [INSTR_W-1:0]         head_instr;
  logic [ADDR_W-1:0]          expected_addr;
  logic                       fifo_empty;
  logic                       hit;
  logic                       redirect;
  logic                       push;

  assign {head_addr, head_instr} = head_data;
  assign fifo_empty = (buf_count == '0);

  ipb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({mem_addr, mem_rdata}),
    .pop       (hit),
    .clear     (redirect),
    .head_data (head_data),
    .count     (buf_count)
  );

  // Address the CPU should ask for next, and hit/redirect classification against it
  always_comb begin
    if (!fifo_empty)          expected_addr = head_addr;
    else if (state_q == WAIT) expected_addr = mem_addr;
    else                      expected_addr = issue_addr_q;
    hit         = cpu_req && !fifo_empty && (cpu_addr == head_addr);
    redirect    = cpu_req && (cpu_addr != expected_addr);
    fetch_valid = hit;
    fetch_instr = hit ? head_instr : NOP_INSTR;
  end

  // Request sequencing: one outstanding fetch, slot reserved at issue time
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req;
    mem_addr_d   = mem_addr;
    issue_addr_d = issue_addr_q;
    push         = 1'b0;
    if (redirect) issue_addr_d = cpu_addr;
    case (state_q)
      IDLE: begin
        if (!redirect && (buf_count < CNT_W'(DEPTH))) begin
          mem_req_d    = 1'b1;
          mem_addr_d   = issue_addr_q;
          issue_addr_d = issue_addr_q + ADDR_W'(1);
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          push      = !redirect;
          state_d   = IDLE;
        end else if (redirect) begin
          state_d = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and memory-interface registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      issue_addr_q <= RESET_ADDR;
    end else begin
      state_q      <= state_d;
      mem_req      <= mem_req_d;
      mem_addr     <= mem_addr_d;
      issue_addr_q <= issue_addr_d;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb/tb_inst_prefetch_buffer.sv - self-checking bench for inst_prefetch_buffer
module tb_inst_prefetch_buffer;

  localparam int          DEPTH      = 4;
  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_ADDR = 32'h0;
  localparam int          S_IDLE     = 0;
  localparam int          S_WAIT     = 1;
  localparam int          S_DROP     = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic [31:0]   cpu_addr;
  logic          fetch_valid;
  logic [31:0]   fetch_instr;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [CW-1:0] buf_count;

  always #5 clk = ~clk;

  inst_prefetch_buffer #(
    .DEPTH      (DEPTH),
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .buf_count   (buf_count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        sb[$];
  int          m_state;
  logic        m_req;
  logic [31:0] m_mem_addr;
  logic [31:0] m_issue;
  int          mem_lat;
  int          mem_cnt;
  logic        last_hit;
  logic        obs_valid;
  logic [31:0] obs_instr;
  logic [31:0] obs_mem_addr;
  logic        saw_pp = 1'b0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'h1000_0001 + a * 32'd7;
  endfunction

  task automatic check(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_state    = S_IDLE;
    m_req      = 1'b0;
    m_mem_addr = 32'h0;
    m_issue    = RESET_ADDR;
    mem_cnt    = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_addr  = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    @(posedge clk); #1;
    check("rst_buf_count", buf_count === CW'(0), 32'(buf_count), 32'h0);
    check("rst_fetch_valid", fetch_valid === 1'b0, 32'(fetch_valid), 32'h0);
    check("rst_fetch_instr", fetch_instr === 32'h0, fetch_instr, 32'h0);
    check("rst_mem_req", mem_req === 1'b0, 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr === 32'h0, mem_addr, 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Memory responder: acks after mem_lat cycles of a visible request
  task automatic mem_phase();
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_req) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = f(mem_addr);
        mem_cnt   = 0;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  // Compare DUT against the scoreboard, then advance model across the clock edge
  task automatic eval_phase();
    logic [31:0]   ea;
    logic [31:0]   exp_instr;
    logic [31:0]   cur_addr;
    logic          hit;
    logic          redir;
    logic          push;
    logic [CW-1:0] cnt_pre;
    ent_t          head;
    head      = (sb.size() != 0) ? sb[0] : '0;
    ea        = (sb.size() != 0) ? head.addr : ((m_state == S_WAIT) ? m_mem_addr : m_issue);
    redir     = cpu_req && (cpu_addr != ea);
    hit       = cpu_req && (sb.size() != 0) && (cpu_addr == head.addr);
    push      = (m_state == S_WAIT) && mem_ack && !redir;
    exp_instr = hit ? head.instr : 32'h0;
    cnt_pre   = CW'(sb.size());
    #1;
    obs_valid    = fetch_valid;
    obs_instr    = fetch_instr;
    obs_mem_addr = mem_addr;
    check("fetch_valid", fetch_valid === hit, 32'(fetch_valid), 32'(hit));
    check("fetch_instr", fetch_instr === exp_instr, fetch_instr, exp_instr);
    check("buf_count", buf_count === cnt_pre, 32'(buf_count), 32'(cnt_pre));
    check("mem_req", mem_req === m_req, 32'(mem_req), 32'(m_req));
    check("mem_addr", mem_addr === m_mem_addr, mem_addr, m_mem_addr);
    cur_addr = m_mem_addr;
    if (redir) m_issue = cpu_addr;
    case (m_state)
      S_IDLE: if (!redir && sb.size() < DEPTH) begin
        m_req      = 1'b1;
        m_mem_addr = m_issue;
        m_issue    = m_issue + 32'd1;
        m_state    = S_WAIT;
      end
      S_WAIT: if (mem_ack) begin
        m_req   = 1'b0;
        m_state = S_IDLE;
      end else if (redir) begin
        m_state = S_DROP;
      end
      default: if (mem_ack) begin
        m_req   = 1'b0;
        m_state = S_IDLE;
      end
    endcase
    if (redir) sb.delete();
    else begin
      if (hit)  void'(sb.pop_front());
      if (push) sb.push_back({cur_addr, f(cur_addr)});
    end
    last_hit = hit;
    @(posedge clk); #1;
    if (hit && push) begin
      saw_pp = 1'b1;
      check("push_pop_count", buf_count === cnt_pre, 32'(buf_count), 32'(cnt_pre));
    end
  endtask

  task automatic cyc(input logic req, input logic [31:0] addr);
    mem_phase();
    cpu_req  = req;
    cpu_addr = addr;
    eval_phase();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] pc;
    int          first_hit;
    int          k;
    int          acks;
    logic        done;
    logic        acked;

    // Cold start at latency 1, CPU advances only on hits
    mem_lat = 1;
    do_reset();
    pc = 32'h0;
    first_hit = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(1'b1, pc);
      if (obs_valid && first_hit == 0) begin
        first_hit = i;
        check("first_hit_instr", obs_instr === f(32'h0), obs_instr, f(32'h0));
      end
      if (last_hit) pc = pc + 32'd1;
    end
    check("first_hit_cycle", first_hit === 3, 32'(first_hit), 32'd3);

    // Fill with no consumer, then pop one and see refill of addr 4
    do_reset();
    repeat (12) cyc(1'b0, 32'h0);
    check("fill_count", buf_count === CW'(4), 32'(buf_count), 32'd4);
    check("fill_mem_req", mem_req === 1'b0, 32'(mem_req), 32'h0);
    cyc(1'b1, 32'h0);
    check("pop_hit", obs_valid === 1'b1, 32'(obs_valid), 32'h1);
    check("pop_count", buf_count === CW'(3), 32'(buf_count), 32'd3);
    cyc(1'b0, 32'h0);
    check("refill_req", mem_req === 1'b1, 32'(mem_req), 32'h1);
    check("refill_addr", mem_addr === 32'h4, mem_addr, 32'h4);
    pc = 32'h1;
    repeat (30) begin
      cyc(1'b1, pc);
      if (last_hit) pc = pc + 32'd1;
    end
    check("push_pop_seen", saw_pp === 1'b1, 32'(saw_pp), 32'h1);

    // Redirect with a full FIFO
    do_reset();
    repeat (12) cyc(1'b0, 32'h0);
    cyc(1'b1, 32'h20);
    check("redir_valid", obs_valid === 1'b0, 32'(obs_valid), 32'h0);
    check("redir_instr", obs_instr === 32'h0, obs_instr, 32'h0);
    check("redir_count", buf_count === CW'(0), 32'(buf_count), 32'h0);
    k = 0;
    while (!mem_req && k < 10) begin cyc(1'b1, 32'h20); k++; end
    check("redir_issue_addr", mem_addr === 32'h20, mem_addr, 32'h20);
    k = 0;
    do begin cyc(1'b1, 32'h20); k++; end while (!obs_valid && k < 10);
    check("redir_hit_instr", obs_instr === f(32'h20), obs_instr, f(32'h20));

    // Redirect during WAIT at latency 5
    mem_lat = 5;
    do_reset();
    pc = 32'h0;
    done = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      mem_phase();
      cpu_req = 1'b1;
      if (m_state == S_WAIT && m_mem_addr == 32'h5 && !mem_ack) begin
        cpu_addr = 32'h40;
        done = 1'b1;
        eval_phase();
      end else begin
        cpu_addr = pc;
        eval_phase();
        if (last_hit) pc = pc + 32'd1;
      end
      k++;
    end
    check("wait_redir_found", done === 1'b1, 32'(done), 32'h1);
    acked = 1'b0;
    k = 0;
    while (!acked && k < 10) begin
      mem_phase();
      acked    = mem_ack;
      cpu_req  = 1'b1;
      cpu_addr = 32'h40;
      eval_phase();
      check("drop_addr_stable", obs_mem_addr === 32'h5, obs_mem_addr, 32'h5);
      k++;
    end
    check("drop_acked", acked === 1'b1, 32'(acked), 32'h1);
    check("drop_count", buf_count === CW'(0), 32'(buf_count), 32'h0);
    k = 0;
    while (!mem_req && k < 10) begin cyc(1'b1, 32'h40); k++; end
    check("drop_next_addr", mem_addr === 32'h40, mem_addr, 32'h40);

    // Redirect coinciding with an ack
    mem_lat = 3;
    do_reset();
    pc = 32'h0;
    acks = 0;
    done = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      mem_phase();
      cpu_req = 1'b1;
      if (mem_ack && m_state == S_WAIT) acks++;
      if (mem_ack && m_state == S_WAIT && acks == 3) begin
        cpu_addr = 32'h80;
        done = 1'b1;
        eval_phase();
      end else begin
        cpu_addr = pc;
        eval_phase();
        if (last_hit) pc = pc + 32'd1;
      end
      k++;
    end
    check("ackredir_found", done === 1'b1, 32'(done), 32'h1);
    check("ackredir_count", buf_count === CW'(0), 32'(buf_count), 32'h0);
    k = 0;
    while (!mem_req && k < 10) begin cyc(1'b1, 32'h80); k++; end
    check("ackredir_next_addr", mem_addr === 32'h80, mem_addr, 32'h80);
    k = 0;
    do begin cyc(1'b1, 32'h80); k++; end while (!obs_valid && k < 20);
    check("ackredir_hit_instr", obs_instr === f(32'h80), obs_instr, f(32'h80));

    // Asynchronous reset while a request is outstanding
    mem_lat = 1;
    do_reset();
    repeat (6) cyc(1'b0, 32'h0);
    mem_lat = 5;
    repeat (2) cyc(1'b0, 32'h0);
    check("pre_rst_req", mem_req === 1'b1, 32'(mem_req), 32'h1);
    check("pre_rst_count", buf_count === CW'(3), 32'(buf_count), 32'd3);
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("async_rst_req", mem_req === 1'b0, 32'(mem_req), 32'h0);
    check("async_rst_count", buf_count === CW'(0), 32'(buf_count), 32'h0);
    check("async_rst_valid", fetch_valid === 1'b0, 32'(fetch_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    k = 0;
    while (!mem_req && k < 10) begin cyc(1'b0, 32'h0); k++; end
    check("post_rst_addr", mem_addr === RESET_ADDR, mem_addr, RESET_ADDR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
